etapa_if: RTL

//  Instruction-fetch stage: consumer of the decoder's IF-side controls (MEM_RD_I, SEL_DIR, resetIF).

---
 rtl/etapa_if_if.sv | 22 ++
 rtl/etapa_if.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/etapa_if_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// Request is held with imem_rd_n low until imem_ready pulses with the word.
interface etapa_if_if;
  logic [31:0] imem_addr;
  logic        imem_rd_n;
  logic [31:0] imem_data;
  logic        imem_ready;

  modport master (
    output imem_addr,
    output imem_rd_n,
    input  imem_data,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_rd_n,
    output imem_data,
    output imem_ready
  );
endinterface

// File: rtl/etapa_if.sv
// Instruction-fetch stage: PC, imem req/ready fetch, one-entry skid, IF/ID register, j/jr redirects.
// Optional build macro IF_PERF_CNT_EN adds fetch_cnt / flush_cnt performance counters.
module etapa_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_RD_I,
  input  logic [1:0]        SEL_DIR,
  input  logic              resetIF,
  input  logic [25:0]       j_index,
  input  logic [31:0]       jr_addr,
  input  logic              stall,
  etapa_if_if.master        imem,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e      state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] skid_q,       skid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        pend_q,       pend_d;

  logic        redirect;
  logic        flush;
  logic        req_act;
  logic        accept;
  logic        load_valid;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    redirect    = !resetIF && (SEL_DIR == 2'b01 || SEL_DIR == 2'b10);
    flush       = !resetIF;
    pc_plus4    = pc_q + 32'd4;
    redirect_pc = (SEL_DIR == 2'b01) ? {ifid_pc4_q[31:28], j_index, 2'b00}
                                     : {jr_addr[31:2], 2'b00};
    // A request already issued keeps going even if MEM_RD_I rises meanwhile.
    req_act     = (state_q == S_REQ) && !redirect && (!MEM_RD_I || pend_q);
    accept      = req_act && imem.imem_ready;

    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    pend_d       = req_act && !imem.imem_ready;
    load_valid   = 1'b0;

    if (redirect) begin
      // The jump in ID is final: it beats stall and discards any word in flight.
      pc_d         = redirect_pc;
      state_d      = S_REQ;
      pend_d       = 1'b0;
      ifid_instr_d = NOP;
      ifid_pc4_d   = 32'h0;
      ifid_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (flush) begin
            ifid_instr_d = NOP;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            if (accept) pc_d = pc_plus4;
          end else if (accept && stall) begin
            skid_d  = imem.imem_data;
            state_d = S_HOLD;
          end else if (accept) begin
            ifid_instr_d = imem.imem_data;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            load_valid   = 1'b1;
            pc_d         = pc_plus4;
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (flush) begin
            // Flush drops the parked word; the PC still moves past it.
            ifid_instr_d = NOP;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
            pc_d         = pc_plus4;
            state_d      = S_REQ;
          end else if (!stall) begin
            ifid_instr_d = skid_q;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            load_valid   = 1'b1;
            pc_d         = pc_plus4;
            state_d      = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_q       <= NOP;
      ifid_instr_q <= NOP;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      pend_q       <= pend_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_rd_n = reset || !req_act;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc4       = ifid_pc4_q;
  assign ifid_valid     = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + (load_valid ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flush ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
